// File: rtl/nussinov_mem_server_if.sv
// Handshake bundle shared by the nussinov accelerator wrapper, the test host and
// nussinov_mem_server: accelerator read/write beats plus the host SRAM side-port.
interface nussinov_mem_server_if #(
  parameter int MEM_AW = 12
);
  logic              read_enable;
  logic [63:0]       read_addr;
  logic [63:0]       read_size;
  logic              finish_read;
  logic [63:0]       read_ready;
  logic [31:0]       read_data;
  logic              write_enable;
  logic [63:0]       write_addr;
  logic [31:0]       write_data;
  logic              finish_write;
  logic [63:0]       write_ready;
  logic              host_en;
  logic              host_we;
  logic [MEM_AW-1:0] host_addr;
  logic [31:0]       host_wdata;
  logic [31:0]       host_rdata;
  logic              err;
  logic              err_clr;

  modport slave (
    input  read_enable, read_addr, read_size, finish_read,
    input  write_enable, write_addr, write_data, finish_write,
    input  host_en, host_we, host_addr, host_wdata, err_clr,
    output read_ready, read_data, write_ready, host_rdata, err
  );

  modport master (
    output read_enable, read_addr, read_size, finish_read,
    output write_enable, write_addr, write_data, finish_write,
    output host_en, host_we, host_addr, host_wdata, err_clr,
    input  read_ready, read_data, write_ready, host_rdata, err
  );
endinterface

// File: rtl/nussinov_mem_server.sv
// Word-SRAM responder serving the nussinov accelerator's read/write beats, with a
// priority host side-port. Optional beat/stall counters: NUSSINOV_MEM_SERVER_STATS_EN.
//
// state    | meaning
// IDLE     | no beat in flight; read request wins over write request
// RD_FETCH | SRAM read of the latched read index (held while host_en)
// RD_RESP  | read_ready/read_data presented for one cycle
// RD_WAIT  | waiting for finish_read (next beat) or read_enable drop
// WR_RESP  | write_ready presented for one cycle after a commit
// WR_WAIT  | waiting for finish_write (next beat) or write_enable drop
module nussinov_mem_server #(
  parameter int          MEM_AW    = 12,
  parameter int          DEPTH     = 4096,
  parameter logic [63:0] BASE_ADDR = 64'h0,
  parameter logic [31:0] ERR_DATA  = 32'hDEADBEEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  nussinov_mem_server_if.slave bus
`ifdef NUSSINOV_MEM_SERVER_STATS_EN
  ,
  output logic [31:0]          rd_beats,
  output logic [31:0]          wr_beats,
  output logic [31:0]          stall_cycles
`endif
);
  typedef enum logic [2:0] {
    IDLE, RD_FETCH, RD_RESP, RD_WAIT, WR_RESP, WR_WAIT
  } state_t;

  state_t            r_state;
  logic [31:0]       r_mem [DEPTH];
  logic [MEM_AW-1:0] r_rd_idx;
  logic              r_rd_ok;
  logic              r_wr_pend;
  logic              r_read_ready;
  logic              r_write_ready;
  logic              r_err;
  logic [31:0]       r_read_data;
  logic [31:0]       r_host_rdata;

  logic [MEM_AW:0]   w_rd_dec;
  logic [MEM_AW:0]   w_wr_dec;
  logic              w_host_wr;
  logic              w_host_rd;
  logic              w_wr_req;
  logic              w_wr_go;
  logic              w_rd_go;
  logic              w_stall;
  logic              w_err_set;
  logic              w_unused;

  // {legal, word index}
  function automatic logic [MEM_AW:0] f_decode(input logic [63:0] addr);
    logic [63:0] off;
    logic        ok;
    off = addr - BASE_ADDR;
    ok  = (addr >= BASE_ADDR) && (addr[1:0] == 2'b00) && ((off >> 2) < 64'(DEPTH));
    return {ok, off[MEM_AW+1:2]};
  endfunction

  assign w_rd_dec  = f_decode(bus.read_addr);
  assign w_wr_dec  = f_decode(bus.write_addr);
  assign w_host_wr = bus.host_en & bus.host_we;
  assign w_host_rd = bus.host_en & ~bus.host_we;

  // A finish_write seen during a host stall is remembered in r_wr_pend so the beat is not lost.
  assign w_wr_req  = ((r_state == IDLE) & ~bus.read_enable & bus.write_enable)
                   | ((r_state == WR_WAIT) & (bus.finish_write | r_wr_pend));
  assign w_wr_go   = w_wr_req & ~bus.host_en;
  assign w_rd_go   = (r_state == RD_FETCH) & ~bus.host_en;
  assign w_stall   = bus.host_en & ((r_state == RD_FETCH) | w_wr_req);
  assign w_err_set = (w_rd_go & ~r_rd_ok) | (w_wr_go & ~w_wr_dec[MEM_AW]);
  assign w_unused  = ^bus.read_size;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_rd_idx      <= '0;
      r_rd_ok       <= 1'b0;
      r_wr_pend     <= 1'b0;
      r_read_ready  <= 1'b0;
      r_write_ready <= 1'b0;
      r_err         <= 1'b0;
      r_read_data   <= 32'd0;
      r_host_rdata  <= 32'd0;
    end else begin
      r_read_ready  <= 1'b0;
      r_write_ready <= 1'b0;
      r_err         <= w_err_set | (r_err & ~bus.err_clr);

      if (w_host_wr) begin
        r_mem[bus.host_addr] <= bus.host_wdata;
      end else if (w_wr_go && w_wr_dec[MEM_AW]) begin
        r_mem[w_wr_dec[MEM_AW-1:0]] <= bus.write_data;
      end
      if (w_host_rd) begin
        r_host_rdata <= r_mem[bus.host_addr];
      end

      case (r_state)
        IDLE: begin
          if (bus.read_enable) begin
            r_rd_idx <= w_rd_dec[MEM_AW-1:0];
            r_rd_ok  <= w_rd_dec[MEM_AW];
            r_state  <= RD_FETCH;
          end else if (w_wr_go) begin
            r_write_ready <= 1'b1;
            r_state       <= WR_RESP;
          end
        end
        RD_FETCH: begin
          if (w_rd_go) begin
            r_read_data  <= r_rd_ok ? r_mem[r_rd_idx] : ERR_DATA;
            r_read_ready <= 1'b1;
            r_state      <= RD_RESP;
          end
        end
        RD_RESP: r_state <= RD_WAIT;
        RD_WAIT: begin
          if (bus.finish_read) begin
            r_rd_idx <= w_rd_dec[MEM_AW-1:0];
            r_rd_ok  <= w_rd_dec[MEM_AW];
            r_state  <= RD_FETCH;
          end else if (!bus.read_enable) begin
            r_state <= IDLE;
          end
        end
        WR_RESP: r_state <= WR_WAIT;
        WR_WAIT: begin
          if (w_wr_go) begin
            r_wr_pend     <= 1'b0;
            r_write_ready <= 1'b1;
            r_state       <= WR_RESP;
          end else if (bus.finish_write || r_wr_pend) begin
            r_wr_pend <= 1'b1;
          end else if (!bus.write_enable) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.read_ready  = {63'd0, r_read_ready};
  assign bus.write_ready = {63'd0, r_write_ready};
  assign bus.read_data   = r_read_data;
  assign bus.host_rdata  = r_host_rdata;
  assign bus.err         = r_err;

`ifdef NUSSINOV_MEM_SERVER_STATS_EN
  logic [31:0] r_rd_beats;
  logic [31:0] r_wr_beats;
  logic [31:0] r_stall_cycles;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_beats     <= 32'd0;
      r_wr_beats     <= 32'd0;
      r_stall_cycles <= 32'd0;
    end else begin
      if (w_rd_go) r_rd_beats <= r_rd_beats + 32'd1;
      if (w_wr_go) r_wr_beats <= r_wr_beats + 32'd1;
      if (w_stall) r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign rd_beats     = r_rd_beats;
  assign wr_beats     = r_wr_beats;
  assign stall_cycles = r_stall_cycles;
`endif
endmodule

// File: tb/tb_nussinov_mem_server.sv
// Self-checking bench for nussinov_mem_server: read-beat scoreboard, address-decode
// vector table, and hand sequences for write beats, host stalls, arbitration and reset.
module tb_nussinov_mem_server;
  localparam int          MEM_AW = 12;
  localparam int          DEPTH  = 4096;
  localparam logic [63:0] B      = 64'h1000;
  localparam logic [31:0] ERRD   = 32'hDEADBEEF;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  nussinov_mem_server_if #(.MEM_AW(MEM_AW)) bus ();
`ifdef NUSSINOV_MEM_SERVER_STATS_EN
  logic [31:0] rd_beats, wr_beats, stall_cycles;
`endif

  nussinov_mem_server #(
    .MEM_AW(MEM_AW), .DEPTH(DEPTH), .BASE_ADDR(B), .ERR_DATA(ERRD)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
`ifdef NUSSINOV_MEM_SERVER_STATS_EN
    ,
    .rd_beats(rd_beats),
    .wr_beats(wr_beats),
    .stall_cycles(stall_cycles)
`endif
  );

  typedef struct {
    logic [63:0] addr;
    logic [31:0] exp_data;
    logic        exp_err;
  } rd_vec_t;

  int          n_pass = 0;
  int          n_total = 0;
  int          wr_pulses = 0;
  logic        prev_rr = 1'b0;
  logic        prev_wr = 1'b0;
  logic [31:0] sb_q[$];
  logic [31:0] mdl [DEPTH];
  rd_vec_t     vecs [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Read-beat scoreboard and pulse-width monitor
  always @(negedge clk) begin
    if (bus.read_ready != 64'd0) begin
      chk("rd_ready_val", bus.read_ready, 64'd1);
      chk("rd_ready_1cyc", 64'(prev_rr), 64'd0);
      chk("rd_sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) chk("rd_data", 64'(bus.read_data), 64'(sb_q.pop_front()));
    end
    if (bus.write_ready != 64'd0) begin
      wr_pulses++;
      chk("wr_ready_val", bus.write_ready, 64'd1);
      chk("wr_ready_1cyc", 64'(prev_wr), 64'd0);
    end
    prev_rr = (bus.read_ready != 64'd0);
    prev_wr = (bus.write_ready != 64'd0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_rd(output int lat);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.read_ready != 64'd0) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic wait_wr(output int lat);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.write_ready != 64'd0) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic host_write(input int idx, input logic [31:0] d);
    bus.host_en = 1'b1; bus.host_we = 1'b1;
    bus.host_addr = MEM_AW'(idx); bus.host_wdata = d;
    mdl[idx] = d;
    @(negedge clk);
    bus.host_en = 1'b0; bus.host_we = 1'b0;
  endtask

  task automatic host_read(input int idx, output logic [31:0] d);
    bus.host_en = 1'b1; bus.host_we = 1'b0; bus.host_addr = MEM_AW'(idx);
    @(negedge clk);
    bus.host_en = 1'b0;
    d = bus.host_rdata;
  endtask

  task automatic read_seq(input logic [63:0] a0, input int n);
    int lat;
    int w0;
    w0 = int'((a0 - B) >> 2);
    bus.read_addr = a0; bus.read_enable = 1'b1;
    sb_q.push_back(mdl[w0]);
    wait_rd(lat);
    chk("rd_first_lat", 64'(lat), 64'd2);
    for (int i = 1; i < n; i++) begin
      @(negedge clk);
      chk("rd_ready_low_in_wait", bus.read_ready, 64'd0);
      bus.finish_read = 1'b1; bus.read_addr = a0 + 64'(4 * i);
      sb_q.push_back(mdl[w0 + i]);
      @(negedge clk);
      bus.finish_read = 1'b0;
      wait_rd(lat);
      chk("rd_beat_interval", 64'(lat + 2), 64'd3);
    end
    @(negedge clk);
    bus.read_enable = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int          lat;
    int          snap;
    logic [31:0] d;

    vecs[0] = '{B,                      32'd10,         1'b0};
    vecs[1] = '{B + 64'h4,              32'd20,         1'b0};
    vecs[2] = '{B + 64'hC,              32'd40,         1'b0};
    vecs[3] = '{B + 64'h3FFC,           32'h5A5A_0FFF,  1'b0};
    vecs[4] = '{B + 64'h2,              ERRD,           1'b1};
    vecs[5] = '{B + 64'h1,              ERRD,           1'b1};
    vecs[6] = '{B + 64'h3,              ERRD,           1'b1};
    vecs[7] = '{B - 64'h4,              ERRD,           1'b1};
    vecs[8] = '{B + 64'h4000,           ERRD,           1'b1};
    vecs[9] = '{64'hFFFF_FFFF_FFFF_FFFC, ERRD,          1'b1};

    bus.read_enable = 1'b0; bus.read_addr = '0; bus.read_size = 64'd4; bus.finish_read = 1'b0;
    bus.write_enable = 1'b0; bus.write_addr = '0; bus.write_data = '0; bus.finish_write = 1'b0;
    bus.host_en = 1'b0; bus.host_we = 1'b0; bus.host_addr = '0; bus.host_wdata = '0;
    bus.err_clr = 1'b0;
    for (int i = 0; i < DEPTH; i++) mdl[i] = 32'd0;

    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_read_ready", bus.read_ready, 64'd0);
    chk("rst_write_ready", bus.write_ready, 64'd0);
    chk("rst_read_data", 64'(bus.read_data), 64'd0);
    chk("rst_host_rdata", 64'(bus.host_rdata), 64'd0);
    chk("rst_err", 64'(bus.err), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) host_write(i, 32'((i + 1) * 10));
    for (int i = 4; i < 16; i++) host_write(i, 32'h100 + 32'(i));
    host_write(DEPTH - 1, 32'h5A5A_0FFF);
    host_read(2, d);
    chk("host_rd_w2", 64'(d), 64'd30);

    // Four-beat burst from word 0
    read_seq(B, 4);

    // Address-decode table, one beat per record
    foreach (vecs[k]) begin
      bus.read_addr = vecs[k].addr; bus.read_enable = 1'b1;
      sb_q.push_back(vecs[k].exp_data);
      wait_rd(lat);
      chk("vec_lat", 64'(lat), 64'd2);
      @(negedge clk);
      bus.read_enable = 1'b0;
      chk($sformatf("vec%0d_err", k), 64'(bus.err), 64'(vecs[k].exp_err));
      bus.err_clr = 1'b1;
      @(negedge clk);
      bus.err_clr = 1'b0;
      chk($sformatf("vec%0d_err_clr", k), 64'(bus.err), 64'd0);
    end

    // err_clr held while the illegal read sets err: set wins
    bus.err_clr = 1'b1; bus.read_addr = B + 64'h2; bus.read_enable = 1'b1;
    sb_q.push_back(ERRD);
    wait_rd(lat);
    chk("err_set_beats_clr", 64'(bus.err), 64'd1);
    @(negedge clk);
    chk("err_clr_after", 64'(bus.err), 64'd0);
    bus.err_clr = 1'b0; bus.read_enable = 1'b0;
    @(negedge clk);

    // Two write beats, finish_write left high into WR_RESP (must be ignored there)
    snap = wr_pulses;
    bus.write_addr = B + 64'h10; bus.write_data = 32'd7; bus.write_enable = 1'b1;
    mdl[4] = 32'd7;
    wait_wr(lat);
    chk("wr_first_lat", 64'(lat), 64'd1);
    @(negedge clk);
    chk("wr_ready_low_in_wait", bus.write_ready, 64'd0);
    bus.finish_write = 1'b1; bus.write_addr = B + 64'h14; bus.write_data = 32'd9;
    mdl[5] = 32'd9;
    wait_wr(lat);
    chk("wr_second_lat", 64'(lat), 64'd1);
    bus.finish_write = 1'b0; bus.write_enable = 1'b0;
    repeat (2) @(negedge clk);
    chk("wr_pulse_count", 64'(wr_pulses - snap), 64'd2);
    host_read(4, d); chk("wr_w4", 64'(d), 64'd7);
    host_read(5, d); chk("wr_w5", 64'(d), 64'd9);
    host_read(6, d); chk("wr_w6_untouched", 64'(d), 64'h106);
    read_seq(B + 64'h10, 2);

    // Host holds the SRAM for three cycles while the read is in RD_FETCH
`ifdef NUSSINOV_MEM_SERVER_STATS_EN
    snap = int'(stall_cycles);
`endif
    bus.read_addr = B + 64'h8; bus.read_enable = 1'b1;
    sb_q.push_back(mdl[2]);
    @(negedge clk);
    bus.host_en = 1'b1; bus.host_we = 1'b0; bus.host_addr = '0;
    repeat (3) @(negedge clk);
    bus.host_en = 1'b0;
    chk("stall_host_rdata", 64'(bus.host_rdata), 64'(mdl[0]));
    wait_rd(lat);
    chk("stall_rd_lat", 64'(lat + 4), 64'd5);
`ifdef NUSSINOV_MEM_SERVER_STATS_EN
    chk("stall_cycles", 64'(int'(stall_cycles) - snap), 64'd3);
`endif
    @(negedge clk);
    bus.read_enable = 1'b0;
    @(negedge clk);

    // Read and write requested together: read first, write only after read ends
    snap = wr_pulses;
    bus.read_addr = B; bus.read_enable = 1'b1;
    sb_q.push_back(mdl[0]);
    bus.write_addr = B + 64'h1C; bus.write_data = 32'h77; bus.write_enable = 1'b1;
    wait_rd(lat);
    chk("both_rd_lat", 64'(lat), 64'd2);
    @(negedge clk);
    bus.read_enable = 1'b0;
    chk("both_no_wr_during_rd", 64'(wr_pulses - snap), 64'd0);
    wait_wr(lat);
    chk("both_wr_after_rd", 64'(lat), 64'd2);
    mdl[7] = 32'h77;
    bus.write_enable = 1'b0;
    repeat (2) @(negedge clk);
    host_read(7, d); chk("both_w7", 64'(d), 64'h77);

    // Reset in WR_WAIT with err set and nonzero read_data/host_rdata
    bus.read_addr = B + 64'h1; bus.read_enable = 1'b1;
    sb_q.push_back(ERRD);
    wait_rd(lat);
    @(negedge clk);
    bus.read_enable = 1'b0;
    @(negedge clk);
    chk("err_sticky", 64'(bus.err), 64'd1);
    host_read(0, d);
    bus.write_addr = B + 64'h20; bus.write_data = 32'hAA; bus.write_enable = 1'b1;
    mdl[8] = 32'hAA;
    wait_wr(lat);
    chk("rst_wr_lat", 64'(lat), 64'd1);
    @(negedge clk);
    reset_n = 1'b0;
    bus.finish_write = 1'b1; bus.write_addr = B + 64'h24; bus.write_data = 32'hBB;
    #1;
    chk("arst_read_ready", bus.read_ready, 64'd0);
    chk("arst_write_ready", bus.write_ready, 64'd0);
    chk("arst_read_data", 64'(bus.read_data), 64'd0);
    chk("arst_host_rdata", 64'(bus.host_rdata), 64'd0);
    chk("arst_err", 64'(bus.err), 64'd0);
    @(negedge clk);
    bus.finish_write = 1'b0; bus.write_enable = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_err", 64'(bus.err), 64'd0);
    read_seq(B, 4);
    host_read(8, d); chk("post_rst_w8", 64'(d), 64'hAA);
    host_read(9, d); chk("post_rst_w9", 64'(d), 64'h109);

    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/nussinov_mem_server.md
Name: nussinov_mem_server

Overview:
- Memory-side responder directly upstream of the nussinov accelerator wrapper. It serves that wrapper's read-beat and write-beat handshakes from a local word SRAM of 32-bit words.
- A host side-port preloads the input table into the SRAM and reads the results back.
- Sits between the test host / system bus model and the accelerator. Keeps the accelerator's 64-bit handshake signalling unchanged.

Parameters:
- MEM_AW, 12, SRAM word-address width.
- DEPTH, 4096, SRAM words; must equal 2**MEM_AW.
- BASE_ADDR, 64'h0, byte address mapped to SRAM word 0.
- ERR_DATA, 32'hDEADBEEF, data returned for an illegal read.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- read_enable  in  1  accelerator read request level.
- read_addr  in  64  byte address of the current read beat.
- read_size  in  64  read stride; informational only.
- finish_read  in  1  one-cycle pulse: beat consumed, next address valid.
- read_ready  out  64  value 1 for exactly one cycle per read beat, else 0.
- read_data  out  32  beat data; valid while read_ready==1.
- write_enable  in  1  accelerator write request level.
- write_addr  in  64  byte address of the current write beat.
- write_data  in  32  data of the current write beat.
- finish_write  in  1  one-cycle pulse: next write beat presented.
- write_ready  out  64  value 1 for exactly one cycle per committed write beat.
- host_en  in  1  host SRAM access this cycle.
- host_we  in  1  1 = host write, 0 = host read.
- host_addr  in  MEM_AW  host word index.
- host_wdata  in  32  host write data.
- host_rdata  out  32  host read data, valid 1 cycle after a host read.
- err  out  1  sticky illegal-access flag.
- err_clr  in  1  synchronous clear of err.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE.
  - read_ready, write_ready, read_data, host_rdata and err all 0.
  - SRAM contents are not reset.
  - Reset mid-beat aborts the beat with no SRAM write.
- Address decode: idx=(addr-BASE_ADDR)>>2. The address is illegal if any of these holds:
  - addr<BASE_ADDR
  - addr[1:0]!=0
  - idx>=DEPTH
- Illegal access handling:
  - An illegal read returns ERR_DATA.
  - An illegal write is dropped.
  - Either sets err. err_clr clears err; a set and clr in the same cycle leaves err set.
- FSM states: IDLE, RD_FETCH, RD_RESP, RD_WAIT, WR_RESP, WR_WAIT.
- IDLE:
  - read_enable=1 -> RD_FETCH.
  - Otherwise write_enable=1 -> WR_RESP, committing write_data to idx(write_addr) on the transition edge.
  - Read wins when both enables are high.
- RD_FETCH:
  - Issues the SRAM read of idx(read_addr), then goes to RD_RESP.
  - read_data and read_ready are registered on entry to RD_RESP.
- RD_RESP: read_ready=1 for this single cycle, then -> RD_WAIT unconditionally.
- RD_WAIT (read_ready=0):
  - finish_read=1 -> RD_FETCH, sampling the new read_addr that same cycle.
  - Otherwise read_enable=0 -> IDLE.
  - Otherwise hold.
- Read latency: read_ready rises 2 cycles after read_enable is first sampled. Steady-state rate is 1 beat per 3 cycles.
- WR_RESP: write_ready=1 for this single cycle, then -> WR_WAIT.
- WR_WAIT:
  - finish_write=1 -> commit write_data to idx(write_addr) and go to WR_RESP.
  - Otherwise write_enable=0 -> IDLE.
  - Otherwise hold.
- Each write_addr/write_data pair is committed exactly once.
- Host arbitration:
  - Host has priority. Any cycle with host_en=1 stalls every engine transition that touches the SRAM (RD_FETCH->RD_RESP, IDLE->WR_RESP, WR_WAIT->WR_RESP); the FSM holds state.
  - Transitions not touching the SRAM proceed.
- Simultaneous host write and engine access to the same word: the engine is stalled, so there is no collision.
- finish_read or finish_write arriving in any state other than RD_WAIT or WR_WAIT is ignored.

Optional Feature:
- Macro: NUSSINOV_MEM_SERVER_STATS_EN.
- When defined, three extra outputs exist, all clear on reset and wrap at 2**32:
  - rd_beats (32 bits): +1 per read_ready pulse.
  - wr_beats (32 bits): +1 per committed write.
  - stall_cycles (32 bits): +1 per cycle an engine transition is held by host_en.
- When undefined, the ports and counters are absent.

Test Plan:
- Host-write words 0..3 = 10,20,30,40; read_enable with read_addr=BASE_ADDR, stepping +4 after each finish_read, 4 beats -> read_data 10,20,30,40, each read_ready exactly 1 cycle, first pulse 2 cycles after read_enable.
- Write beats at BASE_ADDR+0x10 and +0x14 with data 7,9, using finish_write between beats, then drop write_enable -> host reads words 4,5 = 7,9; FSM back in IDLE; word 6 unchanged.
- read_addr=BASE_ADDR+2 -> read_data=DEADBEEF, err=1; err_clr pulse -> err=0.
- Hold host_en=1 for 3 cycles during RD_FETCH -> read_ready delayed exactly 3 cycles; stall_cycles=3 with the stats macro defined.
- Read_enable and write_enable rise in the same cycle -> the read beat is served first; no SRAM write occurs until the read sequence ends.
- Assert reset_n=0 while in WR_WAIT -> all outputs 0 asynchronously; after release, the next read of the preloaded words returns the pre-reset contents.
